// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit: req/ack data-memory stage with lane steering, strobes,  |
// | load extension and a bus watchdog. Option: LSU_MISALIGN_TRAP_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        START,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   input  logic [2:0]  FUNCT3,
   input  logic        MEMREAD,
   input  logic        MEMWRITE,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [3:0]  MEM_WSTRB,
   output logic [31:0] MEM_WDATA,
   output logic [31:0] RDATA,
   output logic        DONE,
   output logic        ERR,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [7:0] c_last_cnt = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q,     state_d;
   logic [7:0]  cnt_q,       cnt_d;
   logic        mem_req_q,   mem_req_d;
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q,     rdata_d;
   logic        done_q,      done_d;
   logic        err_q,       err_d;
   logic [2:0]  funct3_q,    funct3_d;
   logic [1:0]  off_q,       off_d;

   logic        w_is_half, w_is_word, w_misaligned;
   logic        w_load_ok, w_store_ok, w_legal;
   logic [1:0]  w_off;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;
   logic [7:0]  w_rbyte;
   logic [15:0] w_rhalf;
   logic [31:0] w_rext;

   // Request decode and store steering from the live IDLE-cycle inputs
   always_comb begin
      w_is_half    = (FUNCT3[1:0] == 2'b01);
      w_is_word    = (FUNCT3[1:0] == 2'b10);
      w_misaligned = (w_is_half & ADDR[0]) | (w_is_word & (ADDR[1:0] != 2'b00));
      w_load_ok    = MEMREAD & ~MEMWRITE &
                     ((FUNCT3 == 3'b000) | (FUNCT3 == 3'b001) | (FUNCT3 == 3'b010) |
                      (FUNCT3 == 3'b100) | (FUNCT3 == 3'b101));
      w_store_ok   = MEMWRITE & ~MEMREAD &
                     ((FUNCT3 == 3'b000) | (FUNCT3 == 3'b001) | (FUNCT3 == 3'b010));
`ifdef LSU_MISALIGN_TRAP_EN
      w_legal      = (w_load_ok | w_store_ok) & ~w_misaligned;
`else
      w_legal      = w_load_ok | w_store_ok;
`endif
      // Offending low address bits are forced to natural alignment
      if (w_is_word)      w_off = 2'b00;
      else if (w_is_half) w_off = {ADDR[1], 1'b0};
      else                w_off = ADDR[1:0];

      if (w_is_word) begin
         w_strb  = 4'b1111;
         w_wdata = WDATA;
      end else if (w_is_half) begin
         w_strb  = 4'b0011 << w_off;
         w_wdata = {2{WDATA[15:0]}};
      end else begin
         w_strb  = 4'b0001 << w_off;
         w_wdata = {4{WDATA[7:0]}};
      end
   end

   // Load extraction from the latched lane offset and width
   always_comb begin
      w_rbyte = MEM_RDATA[{off_q, 3'b000} +: 8];
      w_rhalf = MEM_RDATA[{off_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  w_rext = {{24{w_rbyte[7]}}, w_rbyte};
         3'b001:  w_rext = {{16{w_rhalf[15]}}, w_rhalf};
         3'b100:  w_rext = {24'd0, w_rbyte};
         3'b101:  w_rext = {16'd0, w_rhalf};
         default: w_rext = MEM_RDATA;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      funct3_d    = funct3_q;
      off_d       = off_q;
      unique case (state_q)
         S_IDLE: begin
            if (START & (MEMREAD | MEMWRITE)) begin
               if (w_legal) begin
                  state_d     = S_REQ;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = MEMWRITE;
                  mem_addr_d  = {ADDR[31:2], 2'b00};
                  mem_wstrb_d = MEMWRITE ? w_strb : 4'b0000;
                  mem_wdata_d = w_wdata;
                  funct3_d    = FUNCT3;
                  off_d       = w_off;
               end else begin
                  state_d = S_RESP;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (MEM_ACK) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               done_d    = 1'b1;
               if (!mem_we_q) rdata_d = w_rext;
            end else if (cnt_q == c_last_cnt) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wstrb_q <= 4'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
      end
   end

   assign MEM_REQ   = mem_req_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WSTRB = mem_wstrb_q;
   assign MEM_WDATA = mem_wdata_q;
   assign RDATA     = rdata_q;
   assign DONE      = done_q;
   assign ERR       = err_q;
   assign BUSY      = (state_q != S_IDLE) | (START & (MEMREAD | MEMWRITE));

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit: directed self-checking bench for load_store_unit.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RSTN, START, MEMREAD, MEMWRITE, MEM_ACK;
   logic [31:0] ADDR, WDATA, MEM_RDATA;
   logic [2:0]  FUNCT3;
   logic        MEM_REQ, MEM_WE, DONE, ERR, BUSY;
   logic [31:0] MEM_ADDR, MEM_WDATA, RDATA;
   logic [3:0]  MEM_WSTRB;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat, nreq;
   logic        err_seen;
   logic [31:0] snap_addr, snap_wdata;
   logic [3:0]  snap_strb;
   logic        snap_we;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .RSTN(RSTN), .START(START), .ADDR(ADDR), .WDATA(WDATA),
      .FUNCT3(FUNCT3), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
      .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_REQ(MEM_REQ),
      .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WSTRB(MEM_WSTRB),
      .MEM_WDATA(MEM_WDATA), .RDATA(RDATA), .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // ack_after < 0 means the memory never acknowledges
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input int ack_after);
      START = 1'b1; MEMREAD = rd; MEMWRITE = wr; FUNCT3 = f3;
      ADDR = addr; WDATA = wd; MEM_RDATA = rword;
      nreq = 0; err_seen = 1'b0;
      snap_addr = '0; snap_strb = '0; snap_wdata = '0; snap_we = 1'b0;
      step();
      START = 1'b0; MEMREAD = 1'b0; MEMWRITE = 1'b0;
      lat = 1;
      while (!DONE && lat < 50) begin
         if (MEM_REQ) begin
            nreq++;
            if (nreq == 1) begin
               snap_addr = MEM_ADDR; snap_strb = MEM_WSTRB;
               snap_wdata = MEM_WDATA; snap_we = MEM_WE;
            end
            MEM_ACK = (ack_after >= 0) && (nreq > ack_after);
         end
         step();
         MEM_ACK = 1'b0;
         lat++;
      end
      if (!DONE) check("done_within_bound", 32'(DONE), 32'd1);
      err_seen = ERR;
   endtask

   initial begin
      RSTN = 1'b0; START = 1'b0; MEMREAD = 1'b0; MEMWRITE = 1'b0; MEM_ACK = 1'b0;
      ADDR = '0; WDATA = '0; MEM_RDATA = '0; FUNCT3 = '0;
      step(); step();
      check("rst_req",   32'(MEM_REQ), 32'd0);
      check("rst_addr",  MEM_ADDR, 32'd0);
      check("rst_strb",  32'(MEM_WSTRB), 32'd0);
      check("rst_wdata", MEM_WDATA, 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_done",  32'({DONE, ERR, MEM_WE, BUSY}), 32'd0);
      RSTN = 1'b1;
      step();

      // SW, ack in first REQ cycle
      START = 1'b1; MEMWRITE = 1'b1;
      #1 check("busy_comb_start", 32'(BUSY), 32'd1);
      run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      check("sw_addr",  snap_addr, 32'h100);
      check("sw_strb",  32'(snap_strb), 32'hF);
      check("sw_wdata", snap_wdata, 32'hDEADBEEF);
      check("sw_we",    32'(snap_we), 32'd1);
      check("sw_lat",   32'(lat), 32'd2);
      check("sw_err",   32'(err_seen), 32'd0);
      check("sw_rdata_held", RDATA, 32'd0);
      step();
      check("sw_done_pulse", 32'({DONE, BUSY}), 32'd0);

      // SB at byte lane 3
      run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
      check("sb_addr",  snap_addr, 32'h100);
      check("sb_strb",  32'(snap_strb), 32'h8);
      check("sb_wdata", snap_wdata, 32'hA5A5A5A5);
      check("sb_lat",   32'(lat), 32'd3);
      step();

      // SH at upper half
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
      check("sh_strb",  32'(snap_strb), 32'hC);
      check("sh_wdata", snap_wdata, 32'hABCDABCD);
      step();

      // LB / LBU with 3 wait cycles
      run_access(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h11802233, 3);
      check("lb_rdata", RDATA, 32'hFFFFFF80);
      check("lb_lat",   32'(lat), 32'd5);
      check("lb_strb",  32'(snap_strb), 32'h0);
      check("lb_we",    32'(snap_we), 32'd0);
      check("lb_addr",  snap_addr, 32'h200);
      step();
      run_access(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 32'h11802233, 3);
      check("lbu_rdata", RDATA, 32'h00000080);
      check("lbu_lat",   32'(lat), 32'd5);
      step();

      // LW and LHU
      run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, 0);
      check("lw_rdata", RDATA, 32'hCAFEF00D);
      step();
      run_access(1'b1, 1'b0, 3'b101, 32'h406, 32'h0, 32'h9ABC1234, 0);
      check("lhu_rdata", RDATA, 32'h00009ABC);
      step();

      // Misaligned LH
      run_access(1'b1, 1'b0, 3'b001, 32'h301, 32'h0, 32'h12348765, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lh_mis_err",   32'(err_seen), 32'd1);
      check("lh_mis_nreq",  32'(nreq), 32'd0);
      check("lh_mis_lat",   32'(lat), 32'd1);
      check("lh_mis_rdata", RDATA, 32'h00009ABC);
`else
      check("lh_mis_err",   32'(err_seen), 32'd0);
      check("lh_mis_addr",  snap_addr, 32'h300);
      check("lh_mis_rdata", RDATA, 32'hFFFF8765);
`endif
      step();

      // Store does not disturb RDATA
      run_access(1'b0, 1'b1, 3'b010, 32'h500, 32'h55555555, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("st_rdata_held", RDATA, 32'h00009ABC);
`else
      check("st_rdata_held", RDATA, 32'hFFFF8765);
`endif
      step();

      // Watchdog: LW never acknowledged, then a late ack
      run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h77777777, -1);
      check("to_nreq",  32'(nreq), 32'd4);
      check("to_err",   32'(err_seen), 32'd1);
      check("to_lat",   32'(lat), 32'd5);
      check("to_req",   32'(MEM_REQ), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("to_rdata", RDATA, 32'h00009ABC);
`else
      check("to_rdata", RDATA, 32'hFFFF8765);
`endif
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      check("late_ack_done", 32'({DONE, ERR, MEM_REQ}), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("late_ack_rdata", RDATA, 32'h00009ABC);
`else
      check("late_ack_rdata", RDATA, 32'hFFFF8765);
`endif

      // Illegal FUNCT3 load, and both MEMREAD/MEMWRITE set
      run_access(1'b1, 1'b0, 3'b011, 32'h700, 32'h0, 32'h0, 0);
      check("ill_lat",  32'(lat), 32'd1);
      check("ill_err",  32'(err_seen), 32'd1);
      check("ill_nreq", 32'(nreq), 32'd0);
      step();
      run_access(1'b1, 1'b1, 3'b010, 32'h700, 32'h0, 32'h0, 0);
      check("rw_err",  32'(err_seen), 32'd1);
      check("rw_nreq", 32'(nreq), 32'd0);
      step();

      // START with neither MEMREAD nor MEMWRITE is ignored
      START = 1'b1; MEMREAD = 1'b0; MEMWRITE = 1'b0; FUNCT3 = 3'b010;
      #1 check("nop_busy", 32'(BUSY), 32'd0);
      step();
      START = 1'b0;
      check("nop_idle", 32'({MEM_REQ, DONE, BUSY}), 32'd0);
      step();
      check("nop_idle2", 32'({MEM_REQ, DONE, BUSY}), 32'd0);

      // Reset during REQ
      START = 1'b1; MEMREAD = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h800;
      step();
      START = 1'b0; MEMREAD = 1'b0;
      check("rst_mid_req", 32'(MEM_REQ), 32'd1);
      RSTN = 1'b0;
      step();
      check("rst_mid_drop", 32'({MEM_REQ, DONE}), 32'd0);
      check("rst_mid_rdata", RDATA, 32'd0);
      RSTN = 1'b1;
      step();
      check("rst_mid_after", 32'({MEM_REQ, DONE, BUSY}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU: takes the ALU's computed effective address plus the store operand and load/store control, and drives a request/acknowledge data-memory port. It performs byte-lane steering, byte strobes and load sign/zero extension, holding the core via BUSY until the access completes. A watchdog bounds every bus transaction.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles MEM_REQ is held without MEM_ACK before the access is aborted; range 1–255.
- CLK  in  1  sole clock; all state updates on rising edge.
- RSTN  in  1  synchronous, active-low reset, sampled on rising edge of CLK.
- START  in  1  access request, sampled only in IDLE.
- ADDR  in  32  effective byte address (ALU OUT).
- WDATA  in  32  store operand (rs2).
- FUNCT3  in  3  RISC-V load/store width/sign field.
- MEMREAD  in  1  access is a load.
- MEMWRITE  in  1  access is a store.
- MEM_RDATA  in  32  memory read word, valid when MEM_ACK=1.
- MEM_ACK  in  1  memory completion, meaningful only while MEM_REQ=1.
- MEM_REQ  out  1  bus request.
- MEM_WE  out  1  1 = write.
- MEM_ADDR  out  32  word address, {ADDR[31:2],2'b00}.
- MEM_WSTRB  out  4  byte write enables; 0 for loads.
- MEM_WDATA  out  32  lane-replicated store data.
- RDATA  out  32  extended load result.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle error pulse, coincident with DONE.
- BUSY  out  1  combinational stall to core.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: START=1 with exactly one of MEMREAD/MEMWRITE and legal access → latch address, strobe, data, funct3 → REQ. Illegal access → RESP with ERR. START=0 → stay.
- Legal FUNCT3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Anything else, or MEMREAD=MEMWRITE=1, is illegal; MEMREAD=MEMWRITE=0 with START=1 is ignored (stay IDLE).
- REQ: MEM_REQ=1, outputs stable. MEM_ACK=1 → capture MEM_RDATA, → RESP. Counter reaches TIMEOUT_CYCLES → → RESP with ERR, MEM_REQ drops.
- RESP: DONE=1 (ERR if flagged) for one cycle → IDLE.
- Store steering: SB MEM_WDATA={4{WDATA[7:0]}}, MEM_WSTRB=4'b0001<<ADDR[1:0]; SH {2{WDATA[15:0]}}, 4'b0011<<{ADDR[1],1'b0}; SW WDATA, 4'b1111.
- Load extraction: byte MEM_RDATA[8*ADDR[1:0]+:8], half MEM_RDATA[16*ADDR[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- RDATA updated only on successful load completion; held otherwise (stores, errors).
- START while not IDLE ignored. BUSY = (state≠IDLE) | (START & state==IDLE & (MEMREAD|MEMWRITE)).

## Timing
- Reset values: state IDLE, MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_WSTRB 0, MEM_WDATA 0, RDATA 0, DONE 0, ERR 0, counter 0.
- START sampled edge N → MEM_REQ high from N+1; ACK sampled high at edge N+1+k → DONE high in cycle after, i.e. minimum latency START→DONE 2 cycles.
- ACK in the first REQ cycle permitted. ACK while MEM_REQ=0 ignored.
- Timeout: ACK absent for TIMEOUT_CYCLES consecutive REQ cycles → DONE+ERR; late ACK afterwards ignored.
- Illegal access: DONE+ERR one cycle after START, no MEM_REQ ever.
- RSTN low mid-access: next edge returns to IDLE, MEM_REQ=0, no DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half access with ADDR[0]=1 or word access with ADDR[1:0]≠0 is illegal → DONE+ERR, no bus request.
- Undefined: misaligned accesses proceed with offending low bits forced to natural alignment (half: ADDR[0]=0; word: ADDR[1:0]=0); no ERR.

## Test plan
- SW ADDR=0x100 WDATA=0xDEADBEEF, ACK in first REQ cycle → MEM_ADDR=0x100, WSTRB=1111, DONE 2 cycles after START, ERR=0.
- SB ADDR=0x103 WDATA=0x000000A5 → MEM_ADDR=0x100, WSTRB=1000, MEM_WDATA=0xA5A5A5A5.
- LB ADDR=0x202, MEM_RDATA=0x11802233 after 3 wait cycles → RDATA=0xFFFFFF80; LBU same → 0x00000080; DONE 5 cycles after START.
- LH ADDR=0x301: with LSU_MISALIGN_TRAP_EN → DONE+ERR, MEM_REQ never high; without, MEM_RDATA=0x12348765 → RDATA=0xFFFF8765.
- TIMEOUT_CYCLES=4, LW with ACK never asserted → MEM_REQ high exactly 4 cycles, then DONE+ERR, RDATA unchanged.
- RSTN low during REQ → MEM_REQ 0 next cycle, no DONE; FUNCT3=011 load → DONE+ERR one cycle after START.
